// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the write-back pipeline stage register.
//   DEFAULT_*       : default widths used by the stage register parameters
//   CTRL_REG_WRITE  : index of the register-write enable inside the control bits
//   CTRL_MEM_TO_REG : index of the write-back source select inside the control bits
//   wb_payload_t    : one write-back beat at the default widths (ctrl, data, rd)
package pipe_pkg;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_NLANES = 2;
    localparam int DEFAULT_CTRL_W = 2;
    localparam int DEFAULT_RD_W   = 5;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;

    typedef struct packed {
        logic [DEFAULT_CTRL_W-1:0]              ctrl;
        logic [DEFAULT_NLANES*DEFAULT_XLEN-1:0] data;
        logic [DEFAULT_RD_W-1:0]                rd;
    } wb_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One payload register with a valid bit. State changes on the falling clock edge.
//   clock  : pipeline clock (falling edge active)
//   reset  : synchronous active-low; clears valid and payload
//   clear  : invalidates the entry (payload kept); wins over load
//   load   : captures d and marks the entry valid
//   d      : payload to capture
//   valid  : entry holds a live beat
//   q      : stored payload
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(negedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/wb_stage_skid_register.sv
// wb_stage_skid_register
// MEM/WB stage register with a two-entry skid buffer. MAIN drives the outputs,
// SKID catches the beat accepted while the consumer stalls, so in_ready can be
// computed from registered state only.
//
// Handshake: a beat transfers on a falling edge where valid && ready are both
// high on that side; valid never waits for ready, and in_ready never looks at
// out_ready.
//
//   clock     : pipeline clock, state updates on the falling edge
//   reset     : synchronous active-low
//   flush     : drops both held entries and the current input beat
//   in_valid / in_ready / in_ctrl / in_data / in_rd : upstream beat
//   out_valid / out_ready / out_ctrl / out_data / out_rd : downstream beat
//   occupancy : number of held entries (0..2)
module wb_stage_skid_register
    import pipe_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int NLANES  = DEFAULT_NLANES,
    parameter int CTRL_W  = DEFAULT_CTRL_W,
    parameter int RD_W    = DEFAULT_RD_W,
    parameter bit KILL_X0 = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [NLANES*XLEN-1:0] in_data,
    input  logic [RD_W-1:0]        in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [NLANES*XLEN-1:0] out_data,
    output logic [RD_W-1:0]        out_rd,
    output logic [1:0]             occupancy
);

    localparam int DW = NLANES * XLEN;
    localparam int PW = CTRL_W + DW + RD_W;

    logic          main_valid, skid_valid;
    logic [PW-1:0] main_q, skid_q, main_d, in_payload;
    logic          push, pop;
    logic          main_load, main_clear, skid_load, skid_clear;

    assign in_payload = {in_ctrl, in_data, in_rd};

    // SKID being empty is the only space condition: when only MAIN is full
    // an incoming beat can always land in SKID if the consumer stalls.
    assign in_ready = reset && !flush && !skid_valid;
    assign push     = in_valid && in_ready;
    assign pop      = main_valid && out_ready;

    // MAIN refills from SKID first (it is older), otherwise from the input.
    assign main_d     = skid_valid ? skid_q : in_payload;
    assign main_load  = (skid_valid && pop) || (push && (!main_valid || pop));
    assign main_clear = flush || (pop && !skid_valid && !push);
    assign skid_load  = push && main_valid && !pop;
    assign skid_clear = flush || (skid_valid && pop);

    pipe_slot #(.W(PW)) u_main (
        .clock (clock),
        .reset (reset),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clock (clock),
        .reset (reset),
        .clear (skid_clear),
        .load  (skid_load),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign out_valid = main_valid;
    assign out_data  = main_q[RD_W +: DW];
    assign out_rd    = main_q[RD_W-1:0];
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // A bubble must never write back, and neither may a write to x0.
    always_comb begin
        out_ctrl = main_valid ? main_q[PW-1 -: CTRL_W] : '0;
        if (KILL_X0 && (out_rd == '0)) begin
            out_ctrl[CTRL_REG_WRITE] = 1'b0;
        end
    end

endmodule
